// File: rtl/reaction_ctrl.sv
// Reaction-timer sequencing controller: game FSM, LED, random pre-delay and
// millisecond measurement, with a frozen result and display code for the
// seven-segment driver.
module reaction_ctrl #(
  parameter int unsigned TICK_DIV      = 100000,
  parameter int unsigned MAX_MS        = 1000,
  parameter int unsigned DELAY_BASE_MS = 2000,
  parameter int unsigned DELAY_STEP_MS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  output logic        led,
  output logic [11:0] time_ms,
  output logic [1:0]  disp_mode,
  output logic        busy,
  output logic        done
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned TW = 12;
  localparam int unsigned DW = 13;
  localparam int unsigned LW = 16;

  localparam logic [LW-1:0] LFSR_SEED = 16'hACE1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] TIME_MAX  = TW'(MAX_MS);

  localparam logic [1:0] DISP_HI    = 2'd0;
  localparam logic [1:0] DISP_TIME  = 2'd1;
  localparam logic [1:0] DISP_EARLY = 2'd2;
  localparam logic [1:0] DISP_TOUT  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DELAY   = 3'd1,
    S_MEASURE = 3'd2,
    S_RESULT  = 3'd3,
    S_EARLY   = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [DW-1:0] dly_q, dly_d;
  logic [LW-1:0] lfsr_q, lfsr_d;
  logic [TW-1:0] time_q, time_d;
  logic          timeout_q, timeout_d;
  logic          led_q, led_d;
  logic [1:0]    disp_q, disp_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          tick_c;
  logic          lfsr_fb_c;

  assign tick_c    = (presc_q == PRESC_MAX);
  assign lfsr_fb_c = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

  // State, counters, LFSR and all output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      dly_q     <= '0;
      lfsr_q    <= LFSR_SEED;
      time_q    <= '0;
      timeout_q <= 1'b0;
      led_q     <= 1'b0;
      disp_q    <= DISP_HI;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      dly_q     <= dly_d;
      lfsr_q    <= lfsr_d;
      time_q    <= time_d;
      timeout_q <= timeout_d;
      led_q     <= led_d;
      disp_q    <= disp_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic; clear beats stop beats start
  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    time_d    = time_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (!clear && start) begin
          dly_d     = DW'(DELAY_BASE_MS) + DW'(lfsr_q[3:0]) * DW'(DELAY_STEP_MS);
          time_d    = '0;
          timeout_d = 1'b0;
          state_d   = S_DELAY;
        end
      end
      S_DELAY: begin
        if (clear) begin
          state_d   = S_IDLE;
          time_d    = '0;
          timeout_d = 1'b0;
        end else if (stop) begin
          state_d = S_EARLY;
          time_d  = '0;
        end else if (tick_c) begin
          if (dly_q <= DW'(1)) begin
            dly_d   = '0;
            state_d = S_MEASURE;
          end else begin
            dly_d = dly_q - DW'(1);
          end
        end
      end
      S_MEASURE: begin
        if (clear) begin
          state_d   = S_IDLE;
          time_d    = '0;
          timeout_d = 1'b0;
        end else if (tick_c && ((time_q + TW'(1)) >= TIME_MAX)) begin
          // Ceiling reached: timeout takes precedence over a same-cycle stop
          state_d   = S_RESULT;
          time_d    = TIME_MAX;
          timeout_d = 1'b1;
        end else if (stop) begin
          state_d = S_RESULT;
        end else if (tick_c) begin
          time_d = time_q + TW'(1);
        end
      end
      S_RESULT, S_EARLY: begin
        if (clear) begin
          state_d   = S_IDLE;
          time_d    = '0;
          timeout_d = 1'b0;
        end
      end
      default: begin
        state_d   = S_IDLE;
        dly_d     = '0;
        time_d    = '0;
        timeout_d = 1'b0;
      end
    endcase
  end

  // Output, prescaler and LFSR next values derived from the next state
  always_comb begin
    led_d  = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    disp_d = DISP_HI;
    case (state_d)
      S_DELAY:   busy_d = 1'b1;
      S_MEASURE: begin
        led_d  = 1'b1;
        busy_d = 1'b1;
        disp_d = DISP_TIME;
      end
      S_RESULT:  disp_d = timeout_d ? DISP_TOUT : DISP_TIME;
      S_EARLY:   disp_d = DISP_EARLY;
      default:   disp_d = DISP_HI;
    endcase
    if ((state_d != state_q) && ((state_d == S_RESULT) || (state_d == S_EARLY))) begin
      done_d = 1'b1;
    end
    // Prescaler restarts on every state entry so the first tick is a full period away
    if ((state_d != state_q) || tick_c) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end
    lfsr_d = (lfsr_q == '0) ? LFSR_SEED : {lfsr_fb_c, lfsr_q[LW-1:1]};
  end

  assign led       = led_q;
  assign time_ms   = time_q;
  assign disp_mode = disp_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_reaction_ctrl.sv
// Directed plus randomized bench for reaction_ctrl with a small-parameter build.
module tb_reaction_ctrl;

  localparam int TICK = 10;
  localparam int MAXM = 20;
  localparam int BASE = 3;
  localparam int STEP = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stop, clear;
  logic        led;
  logic [11:0] time_ms;
  logic [1:0]  disp_mode;
  logic        busy, done;

  int vectors = 0;
  int miscompares = 0;
  int ncyc;

  reaction_ctrl #(
    .TICK_DIV(TICK), .MAX_MS(MAXM), .DELAY_BASE_MS(BASE), .DELAY_STEP_MS(STEP)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .led(led), .time_ms(time_ms), .disp_mode(disp_mode), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Clock edges seen since reset release; the LFSR has advanced this many times
  always @(posedge clk or negedge rst) begin
    if (!rst) ncyc <= 0;
    else      ncyc <= ncyc + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench did not finish");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Classic right-shifting Fibonacci LFSR (taps 16,14,13,11) from the seed
  function automatic int lfsr_after(input int n);
    int v = 'hACE1;
    for (int i = 0; i < n; i++) begin
      if (v == 0) v = 'hACE1;
      else v = (v >> 1) | ((((v >> 0) ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1) << 15);
    end
    return v;
  endfunction

  task automatic pulse(input logic s, input logic t, input logic c);
    start = s; stop = t; clear = c;
    @(negedge clk);
    start = 1'b0; stop = 1'b0; clear = 1'b0;
  endtask

  task automatic begin_round(output int exp_cyc);
    int l;
    l = lfsr_after(ncyc);
    exp_cyc = TICK * (BASE + STEP * (l & 15));
    pulse(1'b1, 1'b0, 1'b0);
  endtask

  task automatic wait_led(output int cyc);
    cyc = 0;
    while (led !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    int exp_cyc, cyc, w, rose, dones, distinct;
    int seen [16];
    rst = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_led", led, 0);
    chk("rst_time", time_ms, 0);
    chk("rst_disp", disp_mode, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Normal round: delay, counting, stop at 7
    begin_round(exp_cyc);
    chk("start_busy", busy, 1);
    chk("start_led", led, 0);
    wait_led(cyc);
    chk("delay_cycles", cyc, exp_cyc);
    repeat (10) @(negedge clk);
    chk("count1", time_ms, 1);
    repeat (10) @(negedge clk);
    chk("count2", time_ms, 2);
    repeat (10) @(negedge clk);
    chk("count3", time_ms, 3);
    repeat (40) @(negedge clk);
    chk("count7", time_ms, 7);
    pulse(1'b0, 1'b1, 1'b0);
    chk("stop_led", led, 0);
    chk("stop_time", time_ms, 7);
    chk("stop_disp", disp_mode, 1);
    chk("stop_done", done, 1);
    chk("stop_busy", busy, 0);
    @(negedge clk);
    chk("done_once", done, 0);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    repeat (15) @(negedge clk);
    chk("hold_time", time_ms, 7);
    chk("hold_disp", disp_mode, 1);
    chk("hold_led", led, 0);
    chk("hold_busy", busy, 0);
    pulse(1'b0, 1'b0, 1'b1);
    chk("clr_disp", disp_mode, 0);
    chk("clr_time", time_ms, 0);

    // Early press during the pre-delay
    begin_round(exp_cyc);
    repeat (15) @(negedge clk);
    pulse(1'b0, 1'b1, 1'b0);
    chk("early_disp", disp_mode, 2);
    chk("early_done", done, 1);
    chk("early_time", time_ms, 0);
    chk("early_busy", busy, 0);
    rose = 0; dones = 0;
    repeat (200) begin
      @(negedge clk);
      if (led === 1'b1) rose++;
      if (done === 1'b1) dones++;
    end
    chk("early_no_led", rose, 0);
    chk("early_no_redone", dones, 0);
    pulse(1'b0, 1'b0, 1'b1);
    chk("early_clr_disp", disp_mode, 0);
    chk("early_clr_time", time_ms, 0);

    // Timeout with no stop
    begin_round(exp_cyc);
    wait_led(cyc);
    chk("to_delay", cyc, exp_cyc);
    repeat (200) @(negedge clk);
    chk("to_time", time_ms, MAXM);
    chk("to_disp", disp_mode, 3);
    chk("to_led", led, 0);
    chk("to_done", done, 1);
    repeat (30) @(negedge clk);
    chk("to_sat", time_ms, MAXM);
    pulse(1'b0, 1'b0, 1'b1);

    // Stop coincident with the ceiling tick
    begin_round(exp_cyc);
    wait_led(cyc);
    repeat (199) @(negedge clk);
    chk("co_pre", time_ms, MAXM - 1);
    pulse(1'b0, 1'b1, 1'b0);
    chk("co_time", time_ms, MAXM);
    chk("co_disp", disp_mode, 3);
    pulse(1'b0, 1'b0, 1'b1);

    // All three pulses together in MEASURE
    begin_round(exp_cyc);
    wait_led(cyc);
    repeat (15) @(negedge clk);
    pulse(1'b1, 1'b1, 1'b1);
    chk("all_led", led, 0);
    chk("all_time", time_ms, 0);
    chk("all_disp", disp_mode, 0);
    chk("all_busy", busy, 0);
    chk("all_done", done, 0);
    repeat (50) @(negedge clk);
    chk("all_idle", busy, 0);

    // Asynchronous reset mid-measure
    begin_round(exp_cyc);
    wait_led(cyc);
    repeat (25) @(negedge clk);
    chk("ar_pre_led", led, 1);
    chk("ar_pre_time", time_ms, 2);
    #2 rst = 1'b0;
    #1;
    chk("ar_led", led, 0);
    chk("ar_time", time_ms, 0);
    chk("ar_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("ar_disp", disp_mode, 0);

    // Randomized rounds against the model
    for (int r = 0; r < 16; r++) begin
      repeat ($urandom_range(0, 7)) @(negedge clk);
      begin_round(exp_cyc);
      wait_led(cyc);
      chk("rnd_delay", cyc, exp_cyc);
      seen[r] = cyc;
      w = $urandom_range(0, 150);
      repeat (w) @(negedge clk);
      pulse(1'b0, 1'b1, 1'b0);
      chk("rnd_time", time_ms, w / 10);
      chk("rnd_disp", disp_mode, 1);
      pulse(1'b0, 1'b0, 1'b1);
    end
    distinct = 0;
    for (int i = 1; i < 16; i++) if (seen[i] != seen[0]) distinct = 1;
    chk("rnd_delays_vary", distinct, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
